// File: rtl/universal_shift_reg.sv
// universal_shift_reg: hold / shift-right / shift-left / parallel-load register
// with a registered shift-out bit and a saturating shift counter.  Rev 1.0
`default_nettype none

module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           notq,
  output logic                       sout,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       done
);

  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [CW-1:0] cnt_inc;

  // Counter saturates at WIDTH rather than wrapping.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= RESET_VAL;
      sout <= 1'b0;
      cnt  <= '0;
    end else if (en) begin
      case (mode)
        MODE_SHR: begin
          q    <= {sin_r, q[WIDTH-1:1]};
          sout <= q[0];
          cnt  <= cnt_inc;
        end
        MODE_SHL: begin
          q    <= {q[WIDTH-2:0], sin_l};
          sout <= q[WIDTH-1];
          cnt  <= cnt_inc;
        end
        MODE_LOAD: begin
          q    <= d;
          sout <= 1'b0;
          cnt  <= '0;
        end
        MODE_HOLD: begin
          q    <= q;
          sout <= sout;
          cnt  <= cnt;
        end
        default: begin
          q    <= q;
          sout <= sout;
          cnt  <= cnt;
        end
      endcase
    end
  end

  assign notq = ~q;
  assign done = (cnt == CNT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: two WIDTH=8 builds (RESET_VAL 00/5A)
// share stimulus, plus a WIDTH=2 build; expected values are hand-computed.
`default_nettype none

module tb_universal_shift_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for the two 8-bit instances
  logic       rst = 1'b1, en = 1'b0, sin_r = 1'b0, sin_l = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] d = 8'h00;
  // stimulus for the 2-bit instance
  logic       rst2 = 1'b1, en2 = 1'b0, sin_r2 = 1'b0, sin_l2 = 1'b0;
  logic [1:0] mode2 = 2'b00;
  logic [1:0] d2 = 2'b00;

  logic [7:0] qa, nqa, qb, nqb;
  logic       sa, sb_o, da, db;
  logic [3:0] ca, cb;
  logic [1:0] q2, nq2;
  logic       s2, dn2;
  logic [1:0] c2;

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .d(d), .q(qa), .notq(nqa), .sout(sa), .cnt(ca), .done(da));

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h5A)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .d(d), .q(qb), .notq(nqb), .sout(sb_o), .cnt(cb), .done(db));

  universal_shift_reg #(.WIDTH(2), .RESET_VAL(2'b00)) dut_2 (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .sin_r(sin_r2), .sin_l(sin_l2),
    .d(d2), .q(q2), .notq(nq2), .sout(s2), .cnt(c2), .done(dn2));

  typedef struct {
    int         inst;
    string      name;
    logic [7:0] q;
    logic       s;
    logic [3:0] c;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: outputs are stable at the falling edge; check everything queued.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] aq, anq, enq;
      logic       as, adn;
      logic [3:0] ac;
      e = sb.pop_front();
      case (e.inst)
        0:       begin aq = qa; anq = nqa; as = sa;   ac = ca; adn = da;  enq = ~e.q; end
        1:       begin aq = qb; anq = nqb; as = sb_o; ac = cb; adn = db;  enq = ~e.q; end
        default: begin aq = {6'b0, q2}; anq = {6'b0, nq2}; as = s2;
                       ac = {2'b0, c2}; adn = dn2; enq = {6'b0, ~e.q[1:0]}; end
      endcase
      n_checks++;
      if (aq !== e.q || anq !== enq || as !== e.s || ac !== e.c || adn !== e.dn) begin
        n_fail++;
        $display("FAIL %s inst%0d: got q=%h notq=%h sout=%b cnt=%0d done=%b, want q=%h notq=%h sout=%b cnt=%0d done=%b",
                 e.name, e.inst, aq, anq, as, ac, adn, e.q, enq, e.s, e.c, e.dn);
      end
    end
  end

  // One edge on both 8-bit instances; B's q differs only after a reset.
  task automatic step8(input string nm, input logic r, input logic e, input logic [1:0] m,
                       input logic sr, input logic sl, input logic [7:0] dd,
                       input logic [7:0] eqa, input logic [7:0] eqb,
                       input logic es, input logic [3:0] ec);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; d = dd;
    @(posedge clk);
    #1;
    x.name = nm; x.s = es; x.c = ec; x.dn = (ec == 4'd8);
    x.inst = 0; x.q = eqa; sb.push_back(x);
    x.inst = 1; x.q = eqb; sb.push_back(x);
  endtask

  task automatic step2(input string nm, input logic r, input logic e, input logic [1:0] m,
                       input logic sl, input logic [1:0] dd,
                       input logic [1:0] eq, input logic es, input logic [1:0] ec,
                       input logic edn);
    exp_t x;
    @(negedge clk);
    rst2 = r; en2 = e; mode2 = m; sin_l2 = sl; d2 = dd;
    @(posedge clk);
    #1;
    x.name = nm; x.inst = 2; x.q = {6'b0, eq}; x.s = es; x.c = {2'b0, ec}; x.dn = edn;
    sb.push_back(x);
  endtask

  initial begin
    // reset overrides en=1, mode=load, d=FF
    step8("reset",    1, 1, 2'b11, 0, 0, 8'hFF, 8'h00, 8'h5A, 0, 0);
    step8("load_a5",  0, 1, 2'b11, 0, 0, 8'hA5, 8'hA5, 8'hA5, 0, 0);
    step8("shr1",     0, 1, 2'b01, 0, 0, 8'hFF, 8'h52, 8'h52, 1, 1);
    step8("shr2",     0, 1, 2'b01, 0, 1, 8'hFF, 8'h29, 8'h29, 0, 2);
    step8("shr3",     0, 1, 2'b01, 0, 0, 8'h00, 8'h14, 8'h14, 1, 3);
    step8("shr4",     0, 1, 2'b01, 0, 1, 8'h00, 8'h0A, 8'h0A, 0, 4);
    step8("shr5",     0, 1, 2'b01, 0, 0, 8'h00, 8'h05, 8'h05, 0, 5);
    step8("shr6",     0, 1, 2'b01, 0, 0, 8'h00, 8'h02, 8'h02, 1, 6);
    step8("shr7",     0, 1, 2'b01, 0, 0, 8'h00, 8'h01, 8'h01, 0, 7);
    step8("shr8",     0, 1, 2'b01, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8);
    step8("shr9_sat", 0, 1, 2'b01, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8);
    step8("shl_sat",  0, 1, 2'b10, 0, 1, 8'h00, 8'h01, 8'h01, 0, 8);
    step8("load_81",  0, 1, 2'b11, 1, 1, 8'h81, 8'h81, 8'h81, 0, 0);
    step8("shl1",     0, 1, 2'b10, 0, 1, 8'hFF, 8'h03, 8'h03, 1, 1);
    for (int i = 0; i < 3; i++)
      step8("en0_hold", 0, 0, 2'b11, 1, 1, 8'h3C, 8'h03, 8'h03, 1, 1);
    step8("en0_shr",  0, 0, 2'b01, 1, 0, 8'h00, 8'h03, 8'h03, 1, 1);
    step8("load_0f",  0, 1, 2'b11, 0, 0, 8'h0F, 8'h0F, 8'h0F, 0, 0);
    step8("shr_in1",  0, 1, 2'b01, 1, 1, 8'h00, 8'h87, 8'h87, 1, 1);
    step8("shl_in0",  0, 1, 2'b10, 1, 0, 8'hFF, 8'h0E, 8'h0E, 1, 2);
    step8("mode00",   0, 1, 2'b00, 1, 1, 8'hFF, 8'h0E, 8'h0E, 1, 2);
    step8("load_f0",  0, 1, 2'b11, 0, 0, 8'hF0, 8'hF0, 8'hF0, 0, 0);
    step8("f0_shr1",  0, 1, 2'b01, 0, 0, 8'h00, 8'h78, 8'h78, 0, 1);
    step8("f0_shr2",  0, 1, 2'b01, 0, 0, 8'h00, 8'h3C, 8'h3C, 0, 2);
    step8("f0_shr3",  0, 1, 2'b01, 0, 0, 8'h00, 8'h1E, 8'h1E, 0, 3);
    step8("rst_mid",  1, 1, 2'b01, 1, 1, 8'hFF, 8'h00, 8'h5A, 0, 0);
    step8("post_rst", 0, 1, 2'b01, 0, 0, 8'hFF, 8'h00, 8'h2D, 0, 1);
    @(negedge clk);
    en = 1'b0;

    step2("w2_reset", 1, 1, 2'b11, 1, 2'b11, 2'b00, 0, 2'd0, 0);
    step2("w2_load",  0, 1, 2'b11, 0, 2'b10, 2'b10, 0, 2'd0, 0);
    step2("w2_shl1",  0, 1, 2'b10, 1, 2'b00, 2'b01, 1, 2'd1, 0);
    step2("w2_shl2",  0, 1, 2'b10, 1, 2'b00, 2'b11, 0, 2'd2, 1);
    step2("w2_sat",   0, 1, 2'b10, 1, 2'b00, 2'b11, 1, 2'd2, 1);

    // bounded drain of the scoreboard
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
